// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry FF, LSB first, WIDTH cycles per operation.
// Optional SERIAL_ADDER_SUB_EN adds a `sub` input that computes a-b (two's complement, carry=1 means no borrow).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic             w_s;
  logic             w_co;
  logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so the carry FF is seeded with 1.
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  assign w_s    = r_sh_a[0] ^ r_sh_b[0] ^ r_c;
  assign w_co   = (r_sh_a[0] & r_sh_b[0]) | (r_sh_a[0] & r_c) | (r_sh_b[0] & r_c);
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_sum       <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sh_a     <= a;
            r_sh_b     <= w_b_load;
            r_c        <= w_c_load;
            r_cnt      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_sh_a <= r_sh_a >> 1;
          r_sh_b <= r_sh_b >> 1;
          r_sum  <= {w_s, r_sum[WIDTH-1:1]};
          r_c    <= w_co;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign carry     = r_c;

endmodule

// File: tb/tb_serial_adder.sv
// Directed plus randomized bench for serial_adder (WIDTH=8), arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub_i = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry;
  logic         busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, wait for result, hold under backpressure, release.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                    input logic ts, input int bp, input bit junk);
    int lat;
    int exp_full;
    logic [W-1:0] exp_sum;
    logic         exp_c;
    if (ts) exp_full = int'(ta) + int'(~tb & 8'hFF) + 1;
    else    exp_full = int'(ta) + int'(tb) + int'(tc);
    exp_sum = exp_full[W-1:0];
    exp_c   = exp_full[W];

    chk("pre_in_ready", in_ready, 1);
    a = ta; b = tb; cin = tc; sub_i = ts; in_valid = 1'b1;
    step();
    chk("accept_busy", busy, 1);
    chk("accept_in_ready", in_ready, 0);
    if (junk) begin
      a = 8'h11; b = 8'h11; cin = ~tc; sub_i = ~ts;
    end else begin
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    out_ready = (bp == 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
      if (junk && lat == 3) begin a = W'($urandom); b = W'($urandom); end
    end
    in_valid = 1'b0;
    chk("latency", lat, W);
    chk("sum", sum, exp_sum);
    chk("carry", carry, exp_c);
    chk("done_busy", busy, 0);
    for (int i = 0; i < bp; i++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, exp_sum);
      chk("bp_carry", carry, exp_c);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    // Reset state
    #12;
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);

    // Directed cases
    op(8'h35, 8'h4A, 1'b0, 1'b0, 0, 1'b0);
    op(8'hFF, 8'h01, 1'b1, 1'b0, 0, 1'b0);
    op(8'h80, 8'h80, 1'b0, 1'b0, 2, 1'b0);
    op(8'h22, 8'h33, 1'b0, 1'b0, 5, 1'b1);
    op(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    op(8'hFF, 8'hFF, 1'b1, 1'b0, 1, 1'b0);

    // Abort mid-RUN with reset
    a = 8'hAA; b = 8'h55; cin = 1'b0; sub_i = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #2;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_carry", carry, 0);
    #4;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    op(8'h01, 8'h02, 1'b0, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op(8'h10, 8'h03, 1'b0, 1'b1, 0, 1'b0);
    op(8'h03, 8'h10, 1'b1, 1'b1, 1, 1'b0);
`endif

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      logic ts;
`ifdef SERIAL_ADDER_SUB_EN
      ts = 1'($urandom);
`else
      ts = 1'b0;
`endif
      op(W'($urandom), W'($urandom), 1'($urandom), ts,
         int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
